// File: rtl/fp_cmp_pkg.sv
// rtl/fp_cmp_pkg.sv - shared mode codes, flag indices and NaN helpers for fp_compare_pipe
package fp_cmp_pkg;

  localparam logic [1:0] MODE_CMP    = 2'd0;
  localparam logic [1:0] MODE_MIN    = 2'd1;
  localparam logic [1:0] MODE_MAX    = 2'd2;
  localparam logic [1:0] MODE_ABSCMP = 2'd3;

  localparam int FLAG_AEB   = 0;
  localparam int FLAG_AGB   = 1;
  localparam int FLAG_ALB   = 2;
  localparam int FLAG_UNORD = 3;

  // Helpers work on a 64-bit container so any EXP_W/MAN_W up to double fits.
  function automatic logic fp_is_nan(input logic [63:0] v, input int exp_w, input int man_w);
    logic [63:0] exp_mask;
    logic [63:0] man_mask;
    exp_mask = (64'd1 << exp_w) - 64'd1;
    man_mask = (64'd1 << man_w) - 64'd1;
    return (((v >> man_w) & exp_mask) == exp_mask) && ((v & man_mask) != 64'd0);
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// rtl/fp_cmp_core.sv - combinational classify/compare/select for one operand pair
module fp_cmp_core
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic [DATA_W-1:0] result
);

  localparam int MAG_W = DATA_W - 1;

  logic             nan_a, nan_b, unord;
  logic             sign_a, sign_b;
  logic [MAG_W-1:0] mag_a, mag_b;
  logic             mag_lt, mag_gt, both_zero;
  logic             lt, gt;
  logic             alb, agb, aeb;

  always_comb begin
    nan_a     = fp_is_nan(64'(dataa), EXP_W, MAN_W);
    nan_b     = fp_is_nan(64'(datab), EXP_W, MAN_W);
    unord     = nan_a | nan_b;
    sign_a    = dataa[DATA_W-1];
    sign_b    = datab[DATA_W-1];
    mag_a     = dataa[MAG_W-1:0];
    mag_b     = datab[MAG_W-1:0];
    mag_lt    = mag_a < mag_b;
    mag_gt    = mag_a > mag_b;
    both_zero = (mag_a == '0) && (mag_b == '0);

    // Sign-magnitude ordering; +0 and -0 fall into the equal case.
    if (both_zero) begin
      lt = 1'b0;
      gt = 1'b0;
    end else if (sign_a != sign_b) begin
      lt = sign_a;
      gt = sign_b;
    end else if (sign_a) begin
      lt = mag_gt;
      gt = mag_lt;
    end else begin
      lt = mag_lt;
      gt = mag_gt;
    end

    if (mode == MODE_ABSCMP) begin
      alb = mag_lt;
      agb = mag_gt;
    end else begin
      alb = lt;
      agb = gt;
    end
    aeb = !alb && !agb;
    if (unord) begin
      alb = 1'b0;
      agb = 1'b0;
      aeb = 1'b0;
    end

    result = '0;
    case (mode)
      MODE_MIN, MODE_MAX: begin
        if (nan_a && nan_b)          result = DATA_W'(fp_qnan(EXP_W, MAN_W));
        else if (nan_a)              result = datab;
        else if (nan_b)              result = dataa;
        else if (mode == MODE_MIN)   result = gt ? datab : dataa;
        else                         result = lt ? datab : dataa;
      end
      default: begin
        result[FLAG_UNORD] = unord;
        result[FLAG_ALB]   = alb;
        result[FLAG_AGB]   = agb;
        result[FLAG_AEB]   = aeb;
      end
    endcase
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// rtl/fp_compare_pipe.sv - pipelined IEEE-754 compare/min/max unit, one op per clock
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter  int EXP_W   = 8,
  parameter  int MAN_W   = 23,
  parameter  int LATENCY = 3,
  localparam int DATA_W  = 1 + EXP_W + MAN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  if (LATENCY == 1) begin : g_lat1
    logic [DATA_W-1:0] core_res;
    logic [DATA_W-1:0] result_q;
    logic              done_q;

    fp_cmp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DATA_W(DATA_W)) u_core (
      .mode   (mode),
      .dataa  (dataa),
      .datab  (datab),
      .result (core_res)
    );

    always_ff @(posedge clock) begin
      if (reset) begin
        done_q   <= 1'b0;
        result_q <= '0;
      end else begin
        done_q <= clk_en;
        if (clk_en) result_q <= core_res;
      end
    end

    assign result = result_q;
    assign done   = done_q;
  end else begin : g_latn
    logic              s1_vld;
    logic [1:0]        s1_mode;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic [DATA_W-1:0] core_res;

    always_ff @(posedge clock) begin
      if (reset) begin
        s1_vld  <= 1'b0;
        s1_mode <= MODE_CMP;
        s1_a    <= '0;
        s1_b    <= '0;
      end else begin
        s1_vld <= clk_en;
        if (clk_en) begin
          s1_mode <= mode;
          s1_a    <= dataa;
          s1_b    <= datab;
        end
      end
    end

    fp_cmp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DATA_W(DATA_W)) u_core (
      .mode   (s1_mode),
      .dataa  (s1_a),
      .datab  (s1_b),
      .result (core_res)
    );

    // Data only advances with its valid bit, so the last stage holds between ops.
    for (genvar g = 0; g < LATENCY - 1; g++) begin : g_dly
      logic              vld_in, vld;
      logic [DATA_W-1:0] res_in, res;

      if (g == 0) begin : g_first
        assign vld_in = s1_vld;
        assign res_in = core_res;
      end else begin : g_next
        assign vld_in = g_dly[g-1].vld;
        assign res_in = g_dly[g-1].res;
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          vld <= 1'b0;
          res <= '0;
        end else begin
          vld <= vld_in;
          if (vld_in) res <= res_in;
        end
      end
    end

    assign result = g_dly[LATENCY-2].res;
    assign done   = g_dly[LATENCY-2].vld;
  end

endmodule
